lpc_frame_ctrl: RTL and testbench
=================================

LPC_FRAME_CTRL -- requirements
Module: lpc_frame_ctrl

Interface
REQ-001 SHALL have parameter FW, default 16, width of frame length, pitch period and gain fields.
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port sample_en  input  1  one-cycle strobe per synthesized output sample.
REQ-005 SHALL have port param_valid  input  1  frame parameter set offered.
REQ-006 SHALL have port param_ready  output  1  controller can accept a parameter set.
REQ-007 SHALL have port param_v  input  1  voiced flag of offered frame.
REQ-008 SHALL have port param_pitch  input  FW  pitch period in samples of offered frame.
REQ-009 SHALL have port param_gain  input  FW  excitation gain of offered frame.
REQ-010 SHALL have port param_len  input  FW  frame length in samples of offered frame.
REQ-011 SHALL have port v  output  1  voiced flag driven to the excitation generator.
REQ-012 SHALL have port pulserate  output  FW  pitch period driven to the excitation generator.
REQ-013 SHALL have port lpcrate  output  FW  active frame length driven to the excitation generator.
REQ-014 SHALL have port gain  output  FW  active excitation gain.
REQ-015 SHALL have port frame_start  output  1  one-cycle pulse in the first cycle new parameters are on the outputs.
REQ-016 SHALL have port underrun  output  1  one-cycle pulse when a frame ends with no parameter set queued.
REQ-017 SHALL have port busy  output  1  high while state is LOAD or RUN.

Function
REQ-018 SHALL buffer parameter sets {v,pitch,gain,len} in a 2-entry FIFO; param_ready = FIFO not full, from registered occupancy.
REQ-019 SHALL accept a set on a cycle with param_valid & param_ready; a push while full is ignored even if a pop occurs the same cycle.
REQ-020 SHALL allow push and pop in the same cycle at occupancy 1; occupancy stays 1, order preserved.
REQ-021 SHALL implement states IDLE, LOAD, RUN.
REQ-022 IDLE: SHALL move to LOAD on the edge after the FIFO becomes non-empty.
REQ-023 LOAD (exactly one cycle): SHALL pop the head and register it onto v/pulserate/gain/lpcrate, clear the sample counter, then enter RUN; frame_start SHALL be high in the first RUN cycle.
REQ-024 RUN: SHALL increment the FW-bit sample counter on each sample_en; counter and outputs hold when sample_en is low.
REQ-025 Frame end = sample_en with counter == lpcrate-1.
REQ-026 At frame end with FIFO non-empty: SHALL pop, update outputs, clear counter on the same edge, stay in RUN, pulse frame_start next cycle (zero-sample gap).
REQ-027 At frame end with FIFO empty: SHALL pulse underrun next cycle, force gain and v to 0, hold pulserate and lpcrate, return to IDLE.
REQ-028 param_len of 0 SHALL be stored as 1.
REQ-029 param_pitch SHALL pass to pulserate unmodified, 0 included.

Reset
REQ-030 rst SHALL flush the FIFO, return to IDLE, clear the counter, and drive v, pulserate, lpcrate, gain, frame_start, underrun, busy to 0 and param_ready to 1 on the next edge.
REQ-031 rst mid-frame SHALL discard the active frame and all queued sets; no underrun pulse results.
REQ-032 rst SHALL dominate param_valid and sample_en in the same cycle.

Configuration
REQ-033 With macro LPC_UNDERRUN_CNT_EN defined, SHALL add output underrun_cnt (16 bits): increments per underrun pulse, saturates at 65535, cleared by rst.
REQ-034 Without LPC_UNDERRUN_CNT_EN, SHALL have no underrun_cnt port or counter logic; all other behaviour identical.

Verification
REQ-035 Reset then push {v=1,pitch=4,gain=100,len=240} -> busy after 2 cycles; v=1, pulserate=4, lpcrate=240, gain=100; one frame_start.
REQ-036 Same frame queued, second {v=0,pitch=0,gain=50,len=8} pushed, 240 sample_en strobes -> outputs switch on 240th strobe edge; frame_start next cycle; no underrun.
REQ-037 Push 3 sets back-to-back with no sample_en -> first loads, two queue, param_ready=0; third push offered while full not accepted until a frame ends.
REQ-038 Single frame len=4, 4 strobes, nothing queued -> underrun pulse, gain=0, v=0, IDLE; with LPC_UNDERRUN_CNT_EN underrun_cnt=1.
REQ-039 rst asserted after 100 strobes of a len=240 frame with one set queued -> all outputs 0, param_ready=1, no frame_start/underrun until a new push.
REQ-040 Push len=0 -> lpcrate=1; each sample_en ends a frame.

Source files
------------

// File: rtl/lpc_frame_ctrl.sv
// LPC frame parameter controller: queues parameter sets in a 2-deep FIFO and sequences frames by sample count.
// Latency: an accepted set reaches the outputs 2 edges later from IDLE; frames chain with zero-sample gap. Backpressure: param_ready drops while both FIFO slots are full.
// Optional feature: define LPC_UNDERRUN_CNT_EN to add a saturating 16-bit underrun_cnt output.
module lpc_frame_ctrl #(
    parameter int FW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sample_en,
    input  logic          param_valid,
    output logic          param_ready,
    input  logic          param_v,
    input  logic [FW-1:0] param_pitch,
    input  logic [FW-1:0] param_gain,
    input  logic [FW-1:0] param_len,
    output logic          v,
    output logic [FW-1:0] pulserate,
    output logic [FW-1:0] lpcrate,
    output logic [FW-1:0] gain,
    output logic          frame_start,
    output logic          underrun,
`ifdef LPC_UNDERRUN_CNT_EN
    output logic [15:0]   underrun_cnt,
`endif
    output logic          busy
);

    typedef struct packed {
        logic          v;
        logic [FW-1:0] pitch;
        logic [FW-1:0] gain;
        logic [FW-1:0] len;
    } param_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    param_t        fifo_mem_q [2];
    logic          wr_ptr_q, rd_ptr_q;
    logic [1:0]    fifo_cnt_q, fifo_cnt_d;
    logic          fifo_full, fifo_empty;
    logic          push, pop, pop_fire;
    param_t        head, in_set;

    state_t        state_q, state_d;
    logic          v_q, v_d;
    logic [FW-1:0] pulserate_q, pulserate_d;
    logic [FW-1:0] lpcrate_q, lpcrate_d;
    logic [FW-1:0] gain_q, gain_d;
    logic [FW-1:0] sample_cnt_q, sample_cnt_d;
    logic          frame_start_q, frame_start_d;
    logic          underrun_q, underrun_d;
    logic          frame_end;

    // Ready comes from registered occupancy only, so a pop never frees a slot in the same cycle.
    assign fifo_full  = (fifo_cnt_q == 2'd2);
    assign fifo_empty = (fifo_cnt_q == 2'd0);
    assign push       = param_valid & ~fifo_full;
    assign pop_fire   = pop & ~fifo_empty;
    assign head       = fifo_mem_q[rd_ptr_q];
    assign in_set     = '{v: param_v, pitch: param_pitch, gain: param_gain, len: param_len};

    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        case ({push, pop_fire})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= in_set;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fifo_cnt_q <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop_fire) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    assign frame_end = sample_en && (sample_cnt_q == lpcrate_q - FW'(1));

    always_comb begin
        state_d       = state_q;
        pop           = 1'b0;
        v_d           = v_q;
        pulserate_d   = pulserate_q;
        lpcrate_d     = lpcrate_q;
        gain_d        = gain_q;
        sample_cnt_d  = sample_cnt_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                pop           = 1'b1;
                v_d           = head.v;
                pulserate_d   = head.pitch;
                gain_d        = head.gain;
                lpcrate_d     = (head.len == '0) ? FW'(1) : head.len;
                sample_cnt_d  = '0;
                frame_start_d = 1'b1;
                state_d       = RUN;
            end
            RUN: begin
                if (frame_end) begin
                    sample_cnt_d = '0;
                    if (!fifo_empty) begin
                        pop           = 1'b1;
                        v_d           = head.v;
                        pulserate_d   = head.pitch;
                        gain_d        = head.gain;
                        lpcrate_d     = (head.len == '0) ? FW'(1) : head.len;
                        frame_start_d = 1'b1;
                    end else begin
                        // Silence the excitation but keep the rates so the generator stays stable.
                        underrun_d = 1'b1;
                        gain_d     = '0;
                        v_d        = 1'b0;
                        state_d    = IDLE;
                    end
                end else if (sample_en) begin
                    sample_cnt_d = sample_cnt_q + FW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            v_q           <= 1'b0;
            pulserate_q   <= '0;
            lpcrate_q     <= '0;
            gain_q        <= '0;
            sample_cnt_q  <= '0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            v_q           <= v_d;
            pulserate_q   <= pulserate_d;
            lpcrate_q     <= lpcrate_d;
            gain_q        <= gain_d;
            sample_cnt_q  <= sample_cnt_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
        end
    end

`ifdef LPC_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            underrun_cnt_q <= 16'd0;
        end else if (underrun_d && (underrun_cnt_q != 16'hFFFF)) begin
            underrun_cnt_q <= underrun_cnt_q + 16'd1;
        end
    end

    assign underrun_cnt = underrun_cnt_q;
`endif

    assign param_ready = ~fifo_full;
    assign v           = v_q;
    assign pulserate   = pulserate_q;
    assign lpcrate     = lpcrate_q;
    assign gain        = gain_q;
    assign frame_start = frame_start_q;
    assign underrun    = underrun_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_lpc_frame_ctrl.sv
// Directed bench for lpc_frame_ctrl; accepted parameter sets are queued as expected frames and checked on each frame_start.
module tb_lpc_frame_ctrl;
    localparam int FW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          sample_en;
    logic          param_valid;
    logic          param_ready;
    logic          param_v;
    logic [FW-1:0] param_pitch;
    logic [FW-1:0] param_gain;
    logic [FW-1:0] param_len;
    logic          v;
    logic [FW-1:0] pulserate;
    logic [FW-1:0] lpcrate;
    logic [FW-1:0] gain;
    logic          frame_start;
    logic          underrun;
    logic          busy;
`ifdef LPC_UNDERRUN_CNT_EN
    logic [15:0]   underrun_cnt;
`endif

    always #5 clk = ~clk;

    lpc_frame_ctrl #(.FW(FW)) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_en   (sample_en),
        .param_valid (param_valid),
        .param_ready (param_ready),
        .param_v     (param_v),
        .param_pitch (param_pitch),
        .param_gain  (param_gain),
        .param_len   (param_len),
        .v           (v),
        .pulserate   (pulserate),
        .lpcrate     (lpcrate),
        .gain        (gain),
        .frame_start (frame_start),
        .underrun    (underrun),
`ifdef LPC_UNDERRUN_CNT_EN
        .underrun_cnt(underrun_cnt),
`endif
        .busy        (busy)
    );

    typedef struct {
        logic          v;
        logic [FW-1:0] pitch;
        logic [FW-1:0] gain;
        logic [FW-1:0] len;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   fs_seen = 0;
    int   ur_seen = 0;
    logic last_acc = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    // One clock: record any handshake as an expected frame, then score a frame_start against the queue head.
    task automatic tick();
        logic acc;
        exp_t e;
        exp_t h;
        acc     = (param_valid === 1'b1) && (param_ready === 1'b1);
        e.v     = param_v;
        e.pitch = param_pitch;
        e.gain  = param_gain;
        e.len   = (param_len == '0) ? FW'(1) : param_len;
        @(posedge clk);
        #1;
        last_acc = acc;
        if (acc) exp_q.push_back(e);
        if (underrun === 1'b1) ur_seen++;
        if (frame_start === 1'b1) begin
            fs_seen++;
            chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                h = exp_q.pop_front();
                chk("sb_v", 32'(v), 32'(h.v));
                chk("sb_pulserate", 32'(pulserate), 32'(h.pitch));
                chk("sb_gain", 32'(gain), 32'(h.gain));
                chk("sb_lpcrate", 32'(lpcrate), 32'(h.len));
            end
        end
    endtask

    task automatic offer(input logic pv, input int pitch, input int pg, input int plen);
        param_v     = pv;
        param_pitch = FW'(pitch);
        param_gain  = FW'(pg);
        param_len   = FW'(plen);
        param_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (last_acc) break;
        end
        chk("offer_accepted", 32'(last_acc), 32'd1);
        param_valid = 1'b0;
    endtask

    task automatic wait_fs();
        int n0;
        n0 = fs_seen;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (fs_seen != n0) break;
        end
        chk("wait_frame_start", 32'(fs_seen - n0), 32'd1);
    endtask

    initial begin
        int fs0;
        int ur0;
        rst = 1'b1; sample_en = 1'b0; param_valid = 1'b0;
        param_v = 1'b0; param_pitch = '0; param_gain = '0; param_len = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_v", 32'(v), 32'd0);
        chk("rst_pulserate", 32'(pulserate), 32'd0);
        chk("rst_lpcrate", 32'(lpcrate), 32'd0);
        chk("rst_gain", 32'(gain), 32'd0);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(param_ready), 32'd1);

        // First frame from IDLE: busy two edges after the push, then one frame_start.
        fs0 = fs_seen;
        offer(1'b1, 4, 100, 240);
        chk("load_busy_early", 32'(busy), 32'd0);
        tick();
        chk("load_busy", 32'(busy), 32'd1);
        chk("load_no_fs", 32'(frame_start), 32'd0);
        tick();
        chk("first_fs", 32'(frame_start), 32'd1);
        tick();
        chk("first_fs_count", 32'(fs_seen - fs0), 32'd1);

        // Chain a second frame; the switch lands on the 240th strobe, with a pause in the middle.
        offer(1'b0, 0, 50, 8);
        chk("ready_one_queued", 32'(param_ready), 32'd1);
        fs0 = fs_seen; ur0 = ur_seen;
        sample_en = 1'b1;
        for (int i = 0; i < 120; i++) tick();
        sample_en = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        sample_en = 1'b1;
        for (int i = 0; i < 119; i++) tick();
        chk("pre_switch_pulserate", 32'(pulserate), 32'd4);
        chk("pre_switch_fs", 32'(fs_seen - fs0), 32'd0);
        tick();
        chk("switch_fs", 32'(frame_start), 32'd1);
        chk("switch_pulserate", 32'(pulserate), 32'd0);
        chk("switch_gain", 32'(gain), 32'd50);
        chk("switch_no_underrun", 32'(ur_seen - ur0), 32'd0);

        // len=8 frame with nothing queued ends in an underrun.
        for (int i = 0; i < 7; i++) tick();
        chk("pre_underrun", 32'(underrun), 32'd0);
        tick();
        chk("underrun_pulse", 32'(underrun), 32'd1);
        chk("underrun_gain", 32'(gain), 32'd0);
        chk("underrun_v", 32'(v), 32'd0);
        chk("underrun_lpcrate_hold", 32'(lpcrate), 32'd8);
        chk("underrun_busy", 32'(busy), 32'd0);
`ifdef LPC_UNDERRUN_CNT_EN
        chk("underrun_cnt_1", 32'(underrun_cnt), 32'd1);
`endif
        sample_en = 1'b0;
        tick();
        chk("underrun_one_cycle", 32'(underrun), 32'd0);

        // Back-to-back pushes fill the FIFO; a further offer stalls until a frame ends.
        fs0 = fs_seen; ur0 = ur_seen;
        offer(1'b1, 11, 21, 2);
        offer(1'b0, 12, 22, 3);
        offer(1'b1, 13, 23, 1);
        chk("full_ready", 32'(param_ready), 32'd0);
        chk("full_active_len", 32'(lpcrate), 32'd2);
        param_v = 1'b1; param_pitch = FW'(5); param_gain = FW'(77); param_len = '0;
        param_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("full_hold", 32'(param_ready), 32'd0);
        end
        sample_en = 1'b1;
        offer(1'b1, 5, 77, 0);
        for (int i = 0; i < 12; i++) tick();
        sample_en = 1'b0;
        chk("chain_fs_count", 32'(fs_seen - fs0), 32'd4);
        chk("chain_sb_drained", 32'(exp_q.size()), 32'd0);
        chk("chain_underrun_count", 32'(ur_seen - ur0), 32'd1);
        chk("len0_lpcrate", 32'(lpcrate), 32'd1);
        chk("len0_pulserate_hold", 32'(pulserate), 32'd5);
`ifdef LPC_UNDERRUN_CNT_EN
        chk("underrun_cnt_2", 32'(underrun_cnt), 32'd2);
`endif

        // Reset mid-frame with a set queued, while valid and sample_en are also high.
        offer(1'b1, 4, 100, 240);
        wait_fs();
        offer(1'b0, 9, 9, 9);
        sample_en = 1'b1;
        for (int i = 0; i < 100; i++) tick();
        rst = 1'b1; param_valid = 1'b1;
        tick();
        rst = 1'b0; param_valid = 1'b0;
        exp_q.delete();
        chk("mid_rst_v", 32'(v), 32'd0);
        chk("mid_rst_pulserate", 32'(pulserate), 32'd0);
        chk("mid_rst_lpcrate", 32'(lpcrate), 32'd0);
        chk("mid_rst_gain", 32'(gain), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(param_ready), 32'd1);
`ifdef LPC_UNDERRUN_CNT_EN
        chk("mid_rst_underrun_cnt", 32'(underrun_cnt), 32'd0);
`endif
        fs0 = fs_seen; ur0 = ur_seen;
        for (int i = 0; i < 10; i++) tick();
        chk("post_rst_no_fs", 32'(fs_seen - fs0), 32'd0);
        chk("post_rst_no_underrun", 32'(ur_seen - ur0), 32'd0);
        chk("post_rst_idle", 32'(busy), 32'd0);
        sample_en = 1'b0;
        offer(1'b1, 6, 60, 3);
        wait_fs();
        chk("post_rst_new_len", 32'(lpcrate), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
